// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants and the fetch queue entry type.
package riscv_pkg;

  localparam int unsigned      XLEN             = 32;
  localparam logic [XLEN-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0]  INSTR_NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0]  PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0]  PC_ALIGN_MASK    = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of {pc, instr} pairs with a single-cycle flush.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [XLEN-1:0]              push_pc,
  input  logic [XLEN-1:0]              push_instr,
  input  logic                         pop,
  output logic [XLEN-1:0]              head_pc,
  output logic [XLEN-1:0]              head_instr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush && push) begin
      mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
    end
  end

  always_comb begin
    head_pc    = mem[rd_ptr].pc;
    head_instr = mem[rd_ptr].instr;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues in-order fetches, queues responses for
// decode, and discards stale responses after a redirect.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [31:0]     imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [31:0]     inst_pc,
  output logic [31:0]     pc_out
);

  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop;

  logic [CW:0]     occupancy;
  logic            req_valid;
  logic            req_fire;
  logic            resp_fire;
  logic            push;
  logic            pop;
  logic            inst_avail;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_instr;

  // Outstanding requests count against the queue so every response has a slot.
  always_comb begin
    occupancy       = {1'b0, count} + {1'b0, inflight};
    req_valid       = !redirect_valid && (occupancy < DEPTH_W);
    req_fire        = req_valid && imem_req_ready;
    resp_fire       = imem_resp_valid && (inflight != '0);
    push            = resp_fire && (drop == '0) && !redirect_valid;
    inst_avail      = (count != '0);
    pop             = inst_avail && inst_ready && !redirect_valid;
    redirect_target = redirect_pc & PC_ALIGN_MASK;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      // A response landing in the redirect cycle is itself stale and is not counted in drop.
      fetch_pc <= redirect_target;
      resp_pc  <= redirect_target;
      inflight <= inflight - CW'(resp_fire);
      drop     <= inflight - CW'(resp_fire);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
      if (resp_fire) begin
        if (drop != '0) drop <= drop - CW'(1);
        else            resp_pc <= resp_pc + PC_STEP;
      end
      inflight <= inflight + CW'(req_fire) - CW'(resp_fire);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_pc    (resp_pc),
    .push_instr (imem_resp_data),
    .pop        (pop),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .count      (count)
  );

  // Empty queue presents a NOP so decode never sees stale storage.
  always_comb begin
    imem_req_valid = rst && req_valid;
    imem_req_addr  = fetch_pc;
    inst_valid     = rst && inst_avail;
    inst_data      = !rst ? '0 : (inst_avail ? head_instr : INSTR_NOP);
    inst_pc        = rst ? head_pc : RESET_PC;
    pc_out         = rst ? fetch_pc : RESET_PC;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4: instruction queue entries, which also bound requests in flight.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port redirect_valid, input, 1 bit: branch or jump redirect from the datapath.
REQ-006 SHALL have port redirect_pc, input, 32 bits: redirect target.
REQ-007 SHALL have port imem_req_valid, output, 1 bit: fetch request to instruction memory.
REQ-008 SHALL have port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-009 SHALL have port imem_req_addr, output, 32 bits: fetch address.
REQ-010 SHALL have port imem_resp_valid, input, 1 bit: in-order response strobe.
REQ-011 SHALL have port imem_resp_data, input, 32 bits: fetched instruction.
REQ-012 SHALL have port inst_valid, output, 1 bit: instruction available to decode.
REQ-013 SHALL have port inst_ready, input, 1 bit: decode consumes the instruction.
REQ-014 SHALL have port inst_data, output, 32 bits: instruction at queue head.
REQ-015 SHALL have port inst_pc, output, 32 bits: PC of inst_data.
REQ-016 SHALL have port pc_out, output, 32 bits: next fetch address (fetch_pc).

Function
REQ-017 SHALL maintain the counters: fetch_pc; resp_pc; count (0..DEPTH queued); inflight (accepted, unanswered); drop (in-flight responses to discard).
REQ-018 SHALL drive imem_req_valid=1 iff count+inflight<DEPTH and redirect_valid=0, with imem_req_addr=fetch_pc.
REQ-019 SHALL hold imem_req_valid and imem_req_addr stable until imem_req_ready, except when withdrawn by redirect.
REQ-020 SHALL, on request handshake, increment fetch_pc by 4 modulo 2^32 (32'hFFFF_FFFC wraps to 0) and increment inflight.
REQ-021 SHALL, on imem_resp_valid with drop>0, discard the response and decrement drop and inflight.
REQ-022 SHALL, on imem_resp_valid with drop=0, push {resp_pc, imem_resp_data}, add 4 to resp_pc and decrement inflight.
REQ-023 SHALL ignore imem_resp_valid while inflight=0 and leave all state unchanged.
REQ-024 SHALL drive inst_valid=(count>0) from registers; a response pushed in cycle N SHALL appear on inst_valid/inst_data in cycle N+1 (no bypass).
REQ-025 SHALL pop the head on inst_valid&&inst_ready; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-026 SHALL, on redirect_valid, give redirect priority over push, pop and request in that cycle: queue cleared (count=0); fetch_pc and resp_pc set to {redirect_pc[31:2],2'b00}; drop set to inflight, less 1 if a response arrives that cycle, which is also discarded.
REQ-027 SHALL allow new requests while drop>0; their responses SHALL be pushed only after all drop responses are discarded.
REQ-028 SHALL guarantee that queue overflow cannot occur, because inflight is counted against DEPTH.

Reset
REQ-029 SHALL, when rst=0 at a clock edge, set count=inflight=drop=0 and fetch_pc=resp_pc=RESET_PC.
REQ-030 SHALL hold imem_req_valid=0 and inst_valid=0 during reset, with inst_data=0, inst_pc=RESET_PC and pc_out=RESET_PC.
REQ-031 SHALL give reset priority over redirect_valid, handshakes and responses in the same cycle.
REQ-032 SHALL require the memory to drop outstanding transactions on reset; responses after reset with inflight=0 are ignored per REQ-023.

Structure
REQ-033 SHALL take XLEN=32, RESET_PC default and INSTR_NOP=32'h0000_0013 from the shared package riscv_pkg.
REQ-034 SHALL implement the queue as one sub-module, fetch_fifo: a synchronous DEPTH-entry FIFO of {pc,instr} with a flush input.

Verification
REQ-035 SHALL test steady streaming: memory always ready, 1-cycle latency, inst_ready=1 -> inst_pc sequence 0,4,8,... one per cycle after a 2-cycle start.
REQ-036 SHALL test backpressure: inst_ready=0 for 10 cycles -> at most 4 requests issued, count=4, imem_req_valid=0, then all drained in order 0,4,8,C.
REQ-037 SHALL test redirect with 2 requests in flight to 32'h100 -> both stale responses dropped, next inst_pc=32'h100, then 32'h104.
REQ-038 SHALL test redirect_pc=32'h203 -> fetch address 32'h200, and redirect in the same cycle as a response and a pop -> queue empty next cycle, response discarded.
REQ-039 SHALL test wrap: redirect to 32'hFFFF_FFFC -> next inst_pc values FFFF_FFFC, then 0000_0000.
REQ-040 SHALL test mid-stream reset with 3 in flight -> next cycle pc_out=RESET_PC and inst_valid=0, and a later spurious imem_resp_valid pushes nothing.
